spi2mem_slave: RTL
==================

// Module: spi2mem_slave
// PURPOSE
//  uC->FPGA SPI write path: write-direction partner of the SPI memory read slave on the diag_* bus.
//  Decodes SPI mode-0 write frames (instr, 16-bit addr, N data bytes).
//  Emits one byte-write strobe per received byte to the memory owner (slu2mem byte-write port).
//  The uC can then set relay memory without the SLU bus. Active only while diag_byps is low.
// PARAMETERS
//  DEPTH     59     number of memory bytes; valid addresses 0..DEPTH-1
//  ADDR_W    8      width of wr_addr
//  RO_BYTES  1      addresses 0..RO_BYTES-1 are read-only (card type); writes dropped
//  WR_INSTR  8'h02  instruction byte that opens a write frame
// PORTS
//  clk        in   1       50MHz system clock
//  reset_n    in   1       synchronous, active-low reset
//  spi_clk    in   1       diag_clk, async; mode 0, sample on rising edge, max clk/8
//  spi_cs_n   in   1       diag_cs_n, async, frame active low
//  spi_mosi   in   1       diag_mosi, async, MSB first
//  wr_en      out  1       one-clk write strobe
//  wr_addr    out  ADDR_W  byte address, valid while wr_en
//  wr_data    out  8       byte data, valid while wr_en
//  busy       out  1       high from frame start (cs_n low seen) until cs_n high seen
//  frame_err  out  1       high if the current/last frame had a dropped byte or bad instr
//  frame_cnt  out  8       count of write frames that ended with >=1 byte written; wraps FF->00
// BEHAVIOUR
//  - Reset (reset_n low at clk edge): all outputs 0, counters 0, sync FFs 0, state WAIT_CS.
//  - Input sync: spi_clk, spi_cs_n, spi_mosi each pass through 2 FFs.
//  - Edge detection: rise = s2 & ~s3 on spi_clk. cs_fall/cs_rise are derived the same way.
//  - States:
//    WAIT_CS: after reset; wait for synced cs_n high, then IDLE. Blocks a frame cut by reset.
//    IDLE -> INSTR on cs_fall: bitcnt=0, frame_err=0, busy=1.
//    INSTR: after 8 bits, go to ADDR_HI if byte==WR_INSTR. Otherwise set frame_err and go to IGNORE.
//    ADDR_HI -> ADDR_LO -> DATA: after 8 bits each, load a 16-bit addr register.
//    DATA: every 8 bits emits a byte, then addr += 1. Addr saturates at 16'hFFFF and does not wrap.
//    IGNORE: discard all bits until cs_rise.
//  - Any state except WAIT_CS: cs_rise -> IDLE, busy=0, partial byte discarded, no strobe.
//    frame_cnt += 1 if this frame wrote at least one byte.
//  - Byte emit: if RO_BYTES <= addr <= DEPTH-1, then wr_en=1 for exactly 1 clk, with
//    wr_addr=addr[ADDR_W-1:0] and wr_data=byte. Otherwise no strobe and frame_err=1.
//  - Latency: wr_en rises 3 clk edges after the clk edge coinciding with the raw spi_clk rising
//    edge of the byte's LSB (2 sync + 1 register). wr_addr/wr_data are registered with wr_en.
//    They hold their value until the next strobe.
//  - Simultaneous: if cs_rise and an spi_clk rise are detected in the same clk, cs_rise wins.
//    That bit is discarded, and a byte completed by it is not written.
//  - cs_fall while busy (glitch, no cs_rise seen) restarts the frame as INSTR.
//  - reset_n low mid-frame: outputs cleared next edge, state WAIT_CS.
//    Remaining bits of that frame produce no strobes.
//  - Bits outside a frame (cs_n high) are ignored. wr_en never asserts two consecutive clks.
// TESTING
//  1 cs low, send 02 00 07 55, cs high -> one wr_en, addr 07, data 55; frame_cnt 0->1; frame_err 0.
//  2 send 02 00 05 11 22 33 -> 3 strobes at 05/11, 06/22, 07/33 in order; frame_cnt +1.
//  3 send 02 00 00 AA (RO), then 02 00 3B 77 (addr 59) -> no strobes; frame_err=1 after each;
//    frame_cnt unchanged.
//  4 send 03 00 07 55 -> no strobe, frame_err=1, busy drops on cs high; next valid frame clears frame_err.
//  5 send 02 00 07 + 5 bits, then cs high -> no strobe; next 02 00 08 C3 writes 08/C3 correctly.
//  6 reset_n low mid-DATA, then release while cs still low and clocks continue -> no strobes;
//    after cs high, frame 02 00 09 5A writes 09/5A.

Source files
------------

// File: rtl/spi2mem_slave_if.sv
// Bus bundle for spi2mem_slave: the raw SPI pins and the byte-write port plus status.
interface spi2mem_slave_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              spi_clk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              frame_err;
  logic [7:0]        frame_cnt;

  modport slave (
    input  spi_clk, spi_cs_n, spi_mosi,
    output wr_en, wr_addr, wr_data, busy, frame_err, frame_cnt
  );

  modport master (
    output spi_clk, spi_cs_n, spi_mosi,
    input  wr_en, wr_addr, wr_data, busy, frame_err, frame_cnt
  );
endinterface

// File: rtl/spi2mem_slave.sv
// SPI mode-0 write-frame decoder: instr byte, 16-bit address, then data bytes,
// each data byte turned into a one-clk byte-write strobe on the memory port.
module spi2mem_slave #(
  parameter int unsigned DEPTH    = 59,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RO_BYTES = 1,
  parameter logic [7:0]  WR_INSTR = 8'h02
) (
  input logic            clk,
  input logic            reset_n,
  spi2mem_slave_if.slave bus
);

  typedef enum logic [2:0] {
    WAIT_CS, IDLE, INSTR, ADDR_HI, ADDR_LO, DATA, IGNORE
  } state_t;

  state_t state, state_next;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic cs_s1, cs_s2, cs_s3;
  logic mosi_s1, mosi_s2;

  logic [2:0]        bitcnt;
  logic [6:0]        shreg;
  logic [15:0]       addr;
  logic              wrote;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              busy_q;
  logic              frame_err_q;
  logic [7:0]        frame_cnt_q;

  logic       spi_rise, cs_rise, cs_fall;
  logic [7:0] shift_next;
  logic       shift_en, byte_done, in_range;

  assign spi_rise   = sclk_s2 & ~sclk_s3;
  assign cs_rise    = cs_s2 & ~cs_s3;
  assign cs_fall    = ~cs_s2 & cs_s3;
  assign shift_next = {shreg, mosi_s2};
  assign in_range   = (addr >= 16'(RO_BYTES)) && (addr <= 16'(DEPTH - 1));

  // Two-FF synchronisers plus one history stage for edge detection on clk/cs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      {sclk_s1, sclk_s2, sclk_s3} <= '0;
      {cs_s1, cs_s2, cs_s3}       <= '0;
      {mosi_s1, mosi_s2}          <= '0;
    end else begin
      sclk_s1 <= bus.spi_clk;  sclk_s2 <= sclk_s1;  sclk_s3 <= sclk_s2;
      cs_s1   <= bus.spi_cs_n; cs_s2   <= cs_s1;    cs_s3   <= cs_s2;
      mosi_s1 <= bus.spi_mosi; mosi_s2 <= mosi_s1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= WAIT_CS;
    else          state <= state_next;
  end

  // Next state; cs_rise outranks cs_fall, which outranks a coincident bit.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    byte_done  = 1'b0;
    if (state == WAIT_CS) begin
      if (cs_s2) state_next = IDLE;
    end else if (cs_rise) begin
      state_next = IDLE;
    end else if (cs_fall) begin
      state_next = INSTR;
    end else if (spi_rise && (state inside {INSTR, ADDR_HI, ADDR_LO, DATA})) begin
      shift_en  = 1'b1;
      byte_done = (bitcnt == 3'd7);
      if (byte_done) begin
        case (state)
          INSTR:   state_next = (shift_next == WR_INSTR) ? ADDR_HI : IGNORE;
          ADDR_HI: state_next = ADDR_LO;
          ADDR_LO: state_next = DATA;
          default: state_next = state;
        endcase
      end
    end
  end

  // Frame datapath: bit shifting, address load/increment, strobe and status.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bitcnt      <= '0;
      shreg       <= '0;
      addr        <= '0;
      wrote       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (state != WAIT_CS) begin
        if (cs_rise) begin
          busy_q <= 1'b0;
          wrote  <= 1'b0;
          if (wrote) frame_cnt_q <= frame_cnt_q + 8'd1;
        end else if (cs_fall) begin
          busy_q      <= 1'b1;
          bitcnt      <= '0;
          frame_err_q <= 1'b0;
          wrote       <= 1'b0;
        end else if (shift_en) begin
          shreg  <= shift_next[6:0];
          bitcnt <= bitcnt + 3'd1;
          if (byte_done) begin
            case (state)
              INSTR:   if (shift_next != WR_INSTR) frame_err_q <= 1'b1;
              ADDR_HI: addr[15:8] <= shift_next;
              ADDR_LO: addr[7:0]  <= shift_next;
              DATA: begin
                if (in_range) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= addr[ADDR_W-1:0];
                  wr_data_q <= shift_next;
                  wrote     <= 1'b1;
                end else begin
                  frame_err_q <= 1'b1;
                end
                if (addr != 16'hFFFF) addr <= addr + 16'd1;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule
